// File: rtl/mc_mips_ctrl.sv
// Multi-cycle control sequencer for the MIPS-lite datapath: steps each
// instruction through FETCH/DECODE/EXE/MEM/WB and counts retired instructions.
module mc_mips_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             zero,
    output logic             pc_we,
    output logic             ir_we,
    output logic             gpr_we,
    output logic             dm_we,
    output logic [1:0]       npc_sel,
    output logic [1:0]       aluop,
    output logic             alu_src,
    output logic [1:0]       ext_op,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wd_sel,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXE    = 4'd2,
        WB_ALU = 4'd3,
        MA     = 4'd4,
        MR     = 4'd5,
        WB_MEM = 4'd6,
        MW     = 4'd7,
        BR     = 4'd8,
        JMP    = 4'd9
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic is_rtype, is_addu, is_subu, is_jr, is_ori, is_lui;
    logic is_lw, is_sw, is_beq, is_j, is_jal;

    always_comb begin
        is_rtype = (op == OP_RTYPE);
        is_addu  = is_rtype && (func == FN_ADDU);
        is_subu  = is_rtype && (func == FN_SUBU);
        is_jr    = is_rtype && (func == FN_JR);
        is_ori   = (op == OP_ORI);
        is_lui   = (op == OP_LUI);
        is_lw    = (op == OP_LW);
        is_sw    = (op == OP_SW);
        is_beq   = (op == OP_BEQ);
        is_j     = (op == OP_J);
        is_jal   = (op == OP_JAL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                if (is_addu || is_subu || is_ori || is_lui) state_d = EXE;
                else if (is_lw || is_sw)                    state_d = MA;
                else if (is_beq)                            state_d = BR;
                else if (is_j || is_jal || is_jr)           state_d = JMP;
                else                                        state_d = FETCH;
            end
            EXE:    state_d = WB_ALU;
            MA:     state_d = is_lw ? MR : MW;
            MR:     state_d = WB_MEM;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        retired_d = retired_q;
        if (state_q == WB_ALU || state_q == WB_MEM || state_q == MW ||
            state_q == BR || state_q == JMP)
            retired_d = retired_q + CNT_W'(1);
    end

    always_comb begin
        pc_we   = 1'b0;
        ir_we   = 1'b0;
        gpr_we  = 1'b0;
        dm_we   = 1'b0;
        npc_sel = '0;
        aluop   = '0;
        alu_src = 1'b0;
        ext_op  = '0;
        reg_dst = '0;
        wd_sel  = '0;
        illegal = 1'b0;
        case (state_q)
            FETCH: begin
                ir_we = 1'b1;
                pc_we = 1'b1;
            end
            DECODE: begin
                illegal = !(is_addu || is_subu || is_ori || is_lui || is_lw ||
                            is_sw || is_beq || is_j || is_jal || is_jr);
            end
            EXE, WB_ALU: begin
                if (is_subu) aluop = 2'b01;
                else if (is_ori) begin
                    aluop   = 2'b10;
                    alu_src = 1'b1;
                end else if (is_lui) begin
                    aluop   = 2'b11;
                    alu_src = 1'b1;
                    ext_op  = 2'b10;
                end
                if (state_q == WB_ALU) begin
                    gpr_we  = 1'b1;
                    reg_dst = is_rtype ? 2'b01 : 2'b00;
                end
            end
            MA, MR, MW: begin
                alu_src = 1'b1;
                ext_op  = 2'b01;
                dm_we   = (state_q == MW);
            end
            WB_MEM: begin
                gpr_we = 1'b1;
                wd_sel = 2'b01;
            end
            BR: begin
                aluop   = 2'b01;
                npc_sel = 2'b01;
                pc_we   = zero;
            end
            JMP: begin
                pc_we   = 1'b1;
                npc_sel = is_jr ? 2'b11 : 2'b10;
                if (is_jal) begin
                    gpr_we  = 1'b1;
                    reg_dst = 2'b10;
                    wd_sel  = 2'b10;
                end
            end
            default: ;
        endcase
        // Reset must kill every write strobe at once, before the state flop settles.
        if (reset) begin
            pc_we   = 1'b0;
            ir_we   = 1'b0;
            gpr_we  = 1'b0;
            dm_we   = 1'b0;
            illegal = 1'b0;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule
